// File: rtl/mux_scan_n_if.sv
`default_nettype none
// ============================================================================
// mux_scan_n_if : channel bank, control and valid/ready sample bus of mux_scan_n
// Revision      : 1.0
// ============================================================================
interface mux_scan_n_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic [CHANNELS*WIDTH-1:0] i_in;
    logic [SEL_W-1:0]          i_sel;
    logic                      i_mode;
    logic                      i_en;
    logic                      i_out_ready;
    logic [WIDTH-1:0]          o_out;
    logic [SEL_W-1:0]          o_out_ch;
    logic                      o_out_valid;
    logic                      o_sel_err;

    modport slave (
        input  i_in, i_sel, i_mode, i_en, i_out_ready,
        output o_out, o_out_ch, o_out_valid, o_sel_err
    );

    modport master (
        output i_in, i_sel, i_mode, i_en, i_out_ready,
        input  o_out, o_out_ch, o_out_valid, o_sel_err
    );
endinterface
`default_nettype wire

// File: rtl/mux_scan_n.sv
`default_nettype none
// ============================================================================
// mux_scan_n : registered N-channel mux, manual select or round-robin scan
// Revision   : 1.0
// ============================================================================
module mux_scan_n #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 8
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    mux_scan_n_if.slave bus
);
    localparam int                c_NSLOT   = 2**SEL_W;
    localparam logic [SEL_W-1:0]  c_LAST    = SEL_W'(CHANNELS-1);
    localparam logic [7:0]        c_DW_LAST = 8'(DWELL-1);
    localparam logic [SEL_W:0]    c_NCH     = (SEL_W+1)'(CHANNELS);

    typedef enum logic [1:0] {IDLE, MAN, SCAN} state_t;

    state_t            r_state;
    logic [SEL_W-1:0]  r_ptr;
    logic [7:0]        r_cnt;
    logic [WIDTH-1:0]  r_out;
    logic [SEL_W-1:0]  r_out_ch;
    logic              r_valid;
    logic              r_err;

    // Unused select codes read as zero, which gives the out-of-range sample value.
    logic [WIDTH-1:0]  w_ch [c_NSLOT];

    generate
        for (genvar k = 0; k < c_NSLOT; k++) begin : g_unpack
            if (k < CHANNELS) begin : g_used
                assign w_ch[k] = bus.i_in[k*WIDTH +: WIDTH];
            end else begin : g_pad
                assign w_ch[k] = '0;
            end
        end
    endgenerate

    logic w_slot_free, w_man_cap, w_scan_term, w_scan_cap, w_sel_bad;

    // Captures are suppressed on the cycle a state change is pending.
    assign w_slot_free = !r_valid || bus.i_out_ready;
    assign w_man_cap   = (r_state == MAN) && bus.i_en && !bus.i_mode && w_slot_free;
    assign w_scan_term = (r_cnt == c_DW_LAST);
    assign w_scan_cap  = (r_state == SCAN) && bus.i_en && bus.i_mode && w_scan_term && w_slot_free;
    assign w_sel_bad   = {1'b0, bus.i_sel} >= c_NCH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_out    <= '0;
            r_out_ch <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_man_cap && w_sel_bad;

            if (w_man_cap) begin
                r_out    <= w_ch[bus.i_sel];
                r_out_ch <= bus.i_sel;
                r_valid  <= 1'b1;
            end else if (w_scan_cap) begin
                r_out    <= w_ch[r_ptr];
                r_out_ch <= r_ptr;
                r_valid  <= 1'b1;
            end else if (bus.i_out_ready) begin
                r_valid  <= 1'b0;
            end

            if (!bus.i_en) begin
                r_state <= IDLE;
            end else if (bus.i_mode) begin
                if (r_state != SCAN) begin
                    r_state <= SCAN;
                    r_ptr   <= '0;
                    r_cnt   <= '0;
                end else if (w_scan_term) begin
                    // Counter saturates at terminal count until the slot frees up.
                    if (w_slot_free) begin
                        r_cnt <= '0;
                        r_ptr <= (r_ptr == c_LAST) ? '0 : r_ptr + 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end else begin
                r_state <= MAN;
            end
        end
    end

    assign bus.o_out       = r_out;
    assign bus.o_out_ch    = r_out_ch;
    assign bus.o_out_valid = r_valid;
    assign bus.o_sel_err   = r_err;
endmodule
`default_nettype wire

// File: tb/tb_mux_scan_n.sv
`default_nettype none
// Directed bench for mux_scan_n: three instances (DWELL=4, 3-channel, DWELL=1);
// scan-mode samples on instance A are checked in order against a queue of expected {ch,data}.
module tb_mux_scan_n;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_scan_n_if #(.WIDTH(4), .CHANNELS(4), .SEL_W(2)) ifa ();
    mux_scan_n_if #(.WIDTH(4), .CHANNELS(3), .SEL_W(2)) ifb ();
    mux_scan_n_if #(.WIDTH(4), .CHANNELS(4), .SEL_W(2)) ifc ();

    mux_scan_n #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    mux_scan_n #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    mux_scan_n #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    int         total = 0;
    int         bad   = 0;
    bit         sb_on = 1'b0;
    logic [5:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are already set for the coming edge, so a handshake seen here is consumed by it.
    task automatic step();
        logic [5:0] e;
        if (sb_on && ifa.o_out_valid && ifa.i_out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_extra", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("sb_sample", 32'({ifa.o_out_ch, ifa.o_out}), 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!ifa.o_out_valid && n < 12);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        ifa.i_in = 16'hDCBA; ifa.i_sel = 2'd0; ifa.i_mode = 1'b0; ifa.i_en = 1'b0; ifa.i_out_ready = 1'b1;
        ifb.i_in = 12'hCBA;  ifb.i_sel = 2'd0; ifb.i_mode = 1'b0; ifb.i_en = 1'b0; ifb.i_out_ready = 1'b1;
        ifc.i_in = 16'h4321; ifc.i_sel = 2'd0; ifc.i_mode = 1'b1; ifc.i_en = 1'b0; ifc.i_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_out",   32'(ifa.o_out),       32'd0);
        chk("rst_ch",    32'(ifa.o_out_ch),    32'd0);
        chk("rst_valid", 32'(ifa.o_out_valid), 32'd0);
        chk("rst_err",   32'(ifa.o_sel_err),   32'd0);

        // Manual mode: IDLE->MAN edge, then capture on the following edge
        ifa.i_en = 1'b1; ifa.i_sel = 2'd2;
        wait_valid(n);
        chk("man_first_lat", 32'(n), 32'd2);
        chk("man_out",   32'(ifa.o_out),    32'hC);
        chk("man_ch",    32'(ifa.o_out_ch), 32'd2);
        ifa.i_sel = 2'd1;
        step();
        chk("man_lat1_out", 32'(ifa.o_out),    32'hB);
        chk("man_lat1_ch",  32'(ifa.o_out_ch), 32'd1);

        // Asynchronous reset asserted mid-cycle
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out",   32'(ifa.o_out),       32'd0);
        chk("arst_valid", 32'(ifa.o_out_valid), 32'd0);
        chk("arst_ch",    32'(ifa.o_out_ch),    32'd0);

        // Scan sequence, DWELL=4
        ifa.i_in = 16'h4321; ifa.i_mode = 1'b1;
        sb_on = 1'b1;
        sb_q.push_back({2'd0, 4'd1});
        sb_q.push_back({2'd1, 4'd2});
        sb_q.push_back({2'd2, 4'd3});
        sb_q.push_back({2'd3, 4'd4});
        sb_q.push_back({2'd0, 4'd1});
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_valid(n);
        chk("scan_first_gap", 32'(n), 32'd5);
        for (int i = 0; i < 4; i++) begin
            wait_valid(n);
            chk("scan_gap", 32'(n), 32'd4);
        end

        // Back-pressure after the ch0 capture
        ifa.i_out_ready = 1'b0;
        repeat (10) begin
            step();
            chk("bp_out",   32'(ifa.o_out),       32'd1);
            chk("bp_ch",    32'(ifa.o_out_ch),    32'd0);
            chk("bp_valid", 32'(ifa.o_out_valid), 32'd1);
        end
        sb_q.push_back({2'd1, 4'd2});
        ifa.i_out_ready = 1'b1;
        step();
        chk("bp_resume_valid", 32'(ifa.o_out_valid), 32'd1);
        chk("bp_resume_ch",    32'(ifa.o_out_ch),    32'd1);
        chk("bp_resume_out",   32'(ifa.o_out),       32'd2);

        // Switch to manual at ptr=2 with Sel=1
        ifa.i_mode = 1'b0; ifa.i_sel = 2'd1;
        sb_q.push_back({2'd1, 4'd2});
        wait_valid(n);
        chk("sw_man_lat", 32'(n), 32'd2);
        chk("sw_man_ch",  32'(ifa.o_out_ch), 32'd1);
        chk("sw_man_out", 32'(ifa.o_out),    32'd2);

        // Back to scan with the manual sample pending
        ifa.i_out_ready = 1'b0; ifa.i_mode = 1'b1;
        repeat (2) begin
            step();
            chk("sw_hold_ch",    32'(ifa.o_out_ch),    32'd1);
            chk("sw_hold_out",   32'(ifa.o_out),       32'd2);
            chk("sw_hold_valid", 32'(ifa.o_out_valid), 32'd1);
        end
        ifa.i_out_ready = 1'b1;
        sb_q.push_back({2'd0, 4'd1});
        wait_valid(n);
        chk("sw_scan_restart", 32'(n), 32'd3);
        chk("sw_scan_ch",  32'(ifa.o_out_ch), 32'd0);
        chk("sw_scan_out", 32'(ifa.o_out),    32'd1);

        // Disable with a pending sample
        ifa.i_en = 1'b0; ifa.i_out_ready = 1'b0;
        repeat (3) begin
            step();
            chk("dis_hold_valid", 32'(ifa.o_out_valid), 32'd1);
            chk("dis_hold_ch",    32'(ifa.o_out_ch),    32'd0);
            chk("dis_hold_out",   32'(ifa.o_out),       32'd1);
        end
        ifa.i_out_ready = 1'b1;
        step();
        chk("dis_accept", 32'(ifa.o_out_valid), 32'd0);
        repeat (10) begin
            step();
            chk("dis_idle", 32'(ifa.o_out_valid), 32'd0);
        end
        sb_on = 1'b0;
        chk("sb_left", 32'(sb_q.size()), 32'd0);

        // Select error on the 3-channel instance
        ifb.i_en = 1'b1; ifb.i_sel = 2'd3;
        step();
        chk("err_pre", 32'(ifb.o_sel_err), 32'd0);
        step();
        chk("err_out",   32'(ifb.o_out),       32'd0);
        chk("err_ch",    32'(ifb.o_out_ch),    32'd3);
        chk("err_valid", 32'(ifb.o_out_valid), 32'd1);
        chk("err_pulse", 32'(ifb.o_sel_err),   32'd1);
        ifb.i_sel = 2'd0;
        step();
        chk("err_clear", 32'(ifb.o_sel_err), 32'd0);
        chk("err_next_out", 32'(ifb.o_out),    32'hA);
        chk("err_next_ch",  32'(ifb.o_out_ch), 32'd0);
        ifb.i_en = 1'b0;

        // Full throughput scan, DWELL=1
        ifc.i_en = 1'b1;
        step();
        chk("ft_pre_valid", 32'(ifc.o_out_valid), 32'd0);
        step();
        for (int i = 0; i < 12; i++) begin
            chk("ft_valid", 32'(ifc.o_out_valid), 32'd1);
            chk("ft_ch",    32'(ifc.o_out_ch),    32'(i % 4));
            chk("ft_out",   32'(ifc.o_out),       32'((i % 4) + 1));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mux_scan_n.md
Name: mux_scan_n

Overview:
- Parametrised, registered N-channel, W-bit multiplexer with a valid/ready output handshake.
- Two modes:
  - Manual: Sel chooses the channel.
  - Scan: an internal round-robin sequencer picks each channel in turn, holding for a programmable dwell time between samples.
- Sits between raw input banks and downstream consumers that need a channel-tagged, back-pressurable sample stream.

Parameters:
- WIDTH, 4: bits per channel.
- CHANNELS, 4: number of input channels; legal range 2 to 2**SEL_W.
- SEL_W, 2: select/channel-tag width; must satisfy 2**SEL_W >= CHANNELS.
- DWELL, 8: cycles between scan-mode captures; legal range 1 to 255.

Ports:
- Clk, input, 1: rising-edge clock.
- Rst_n, input, 1: asynchronous active-low reset.
- In, input, CHANNELS*WIDTH: packed channels; channel k occupies In[k*WIDTH +: WIDTH].
- Sel, input, SEL_W: channel select in manual mode.
- Mode, input, 1: 0 = manual, 1 = scan.
- En, input, 1: enables captures.
- Out, output, WIDTH: registered sample.
- Out_ch, output, SEL_W: channel index of Out.
- Out_valid, output, 1: Out/Out_ch hold an unconsumed sample.
- Out_ready, input, 1: consumer accepts the sample when Out_valid && Out_ready.
- Sel_err, output, 1: one-cycle pulse when a manual capture used Sel >= CHANNELS.

Behaviour:
- Reset (Rst_n low, asynchronous): all of the following clear immediately.
  - Outputs: Out=0, Out_ch=0, Out_valid=0, Sel_err=0.
  - Internal state: FSM=IDLE, scan pointer=0, dwell counter=0.
- Slot free condition: `slot_free = !Out_valid || Out_ready`. A capture may occur only when `slot_free` is true.
- Handshake:
  - Out, Out_ch and Out_valid stay stable while Out_valid && !Out_ready.
  - Out_valid clears on acceptance unless a new capture happens in the same cycle; a same-cycle capture keeps Out_valid=1 with the new data.
- FSM states: IDLE, MAN, SCAN.
  - IDLE: entered when En=0. No captures. A pending sample is retained until accepted.
  - IDLE -> MAN when En=1 and Mode=0; IDLE -> SCAN when En=1 and Mode=1.
  - MAN/SCAN -> IDLE when En=0 (next cycle).
  - MAN <-> SCAN follow Mode directly.
  - Any transition into SCAN clears the scan pointer and the dwell counter to 0.
- MAN:
  - Every cycle with slot_free, the register captures In[Sel] and sets Out_ch=Sel and Out_valid=1.
  - Latency: one clock from Sel/In to Out.
  - If Sel >= CHANNELS: Out=0, Out_ch=Sel, Out_valid=1, and Sel_err pulses high for exactly that cycle.
- SCAN, dwell counter:
  - Counts 0..DWELL-1.
  - At count DWELL-1 with slot_free: capture In[ptr], set Out_ch=ptr and Out_valid=1, reset the counter to 0, and advance ptr.
  - ptr wraps CHANNELS-1 -> 0.
- SCAN, back-pressure at terminal count (!slot_free):
  - The counter saturates at DWELL-1 and ptr holds.
  - The capture happens in the first cycle slot_free is true.
  - No channel is ever skipped.
- SCAN, DWELL=1: captures every cycle while slot_free, giving the sequence 0,1,...,CHANNELS-1,0,...
- SCAN: Sel is ignored and Sel_err stays 0.
- Mode change with a pending sample: the sample is kept unchanged until accepted.
- Simultaneous acceptance and capture: the new sample wins; no bubble is inserted.
- Reset mid-stream: the pending sample is lost and Out_valid drops asynchronously.

Test Plan:
1. Reset/manual: assert Rst_n=0 mid-cycle -> Out=0, Out_valid=0 immediately. Release; Mode=0, En=1, Out_ready=1, In=0xDCBA (WIDTH=4), Sel=2 -> next cycle Out=0xC, Out_ch=2, Out_valid=1.
2. Manual select error: CHANNELS=3, SEL_W=2, Sel=3 -> Out=0, Out_ch=3, Sel_err high exactly one cycle, Out_valid=1.
3. Scan sequence: Mode=1, DWELL=4, Out_ready=1, In=0x4321 -> captures every 4 cycles with Out_ch 0,1,2,3,0 and Out 1,2,3,4,1.
4. Back-pressure in scan:
   - Stimulus: hold Out_ready=0 for 10 cycles after the ch0 capture.
   - Required: Out stays 1 / Out_ch stays 0, and the counter saturates.
   - Then raise Out_ready -> ch1 is captured in that same cycle; no channel is skipped.
5. Mode switch/disable:
   - Stimulus: while in scan at ptr=2, drop Mode to 0 with Sel=1.
   - Required: next capture is ch1.
   - Then Mode=1 -> the scan restarts at ch0 after DWELL cycles.
   - Then En=0 -> no further captures, and the pending sample is held until Out_ready.
6. Full throughput: DWELL=1, Out_ready=1 constantly -> Out_valid stays continuously 1 with Out_ch cycling 0..3 with no bubbles.
